// File: rtl/issue_fifo_if.sv
// Decode-to-issue bus for issue_fifo, plus the scoreboard entry type it carries.
// Decode and issue_stage sit on the master side; the FIFO takes the slave modport.
package issue_fifo_pkg;
  typedef struct packed {
    logic [31:0] pc;
    logic [7:0]  op;
    logic [4:0]  rd;
  } scoreboard_entry_t;
endpackage

interface issue_fifo_if #(parameter int unsigned DEPTH = 4);
  import issue_fifo_pkg::*;

  logic                     flush_i;
  scoreboard_entry_t        decoded_instr_i;
  logic                     decoded_instr_valid_i;
  logic                     is_ctrl_flow_i;
  logic                     decoded_instr_ack_o;
  scoreboard_entry_t        issue_instr_o;
  logic                     issue_instr_valid_o;
  logic                     is_ctrl_flow_o;
  logic                     issue_ack_i;
  logic [$clog2(DEPTH):0]   usage_o;
  logic                     full_o;

  modport master (
    output flush_i, decoded_instr_i, decoded_instr_valid_i, is_ctrl_flow_i, issue_ack_i,
    input  decoded_instr_ack_o, issue_instr_o, issue_instr_valid_o, is_ctrl_flow_o, usage_o, full_o
  );
  modport slave (
    input  flush_i, decoded_instr_i, decoded_instr_valid_i, is_ctrl_flow_i, issue_ack_i,
    output decoded_instr_ack_o, issue_instr_o, issue_instr_valid_o, is_ctrl_flow_o, usage_o, full_o
  );
endinterface

// File: rtl/issue_fifo.sv
// Decoded-instruction FIFO between decode and issue, with a cap on buffered branches/jumps.
// Define ISSUE_FIFO_BYPASS_EN to forward an accepted entry straight to issue when the FIFO is empty.
module issue_fifo #(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned MAX_CTRL = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  issue_fifo_if.slave      bus
);
  import issue_fifo_pkg::*;

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned UW = PW + 1;

  scoreboard_entry_t mem_q [DEPTH];
  scoreboard_entry_t mem_d [DEPTH];
  logic [DEPTH-1:0]  ctrl_q, ctrl_d;
  logic [PW-1:0]     wptr_q, wptr_d, rptr_q, rptr_d;
  logic [UW-1:0]     usage_q, usage_d, ctrl_cnt_q, ctrl_cnt_d;
  logic              empty, full, ctrl_full, ack, bypass, push, pop;

  assign empty     = (usage_q == '0);
  assign full      = (usage_q == UW'(DEPTH));
  assign ctrl_full = (ctrl_cnt_q == UW'(MAX_CTRL));
  // Acceptance looks only at registered occupancy, so a same-cycle pop never frees a slot.
  assign ack = rst_ni && bus.decoded_instr_valid_i && !full && !bus.flush_i &&
               !(bus.is_ctrl_flow_i && ctrl_full);

`ifdef ISSUE_FIFO_BYPASS_EN
  assign bypass = empty && ack;
`else
  assign bypass = 1'b0;
`endif

  // A bypassed entry consumed in the same cycle never touches storage or counters.
  assign push = ack && !(bypass && bus.issue_ack_i);
  assign pop  = bus.issue_instr_valid_o && bus.issue_ack_i && !bypass;

  always_comb begin
    bus.issue_instr_o       = mem_q[rptr_q];
    bus.is_ctrl_flow_o      = ctrl_q[rptr_q];
    bus.issue_instr_valid_o = !empty && !bus.flush_i;
    if (bypass) begin
      bus.issue_instr_o       = bus.decoded_instr_i;
      bus.is_ctrl_flow_o      = bus.is_ctrl_flow_i;
      bus.issue_instr_valid_o = 1'b1;
    end
  end

  assign bus.decoded_instr_ack_o = ack;
  assign bus.usage_o             = usage_q;
  assign bus.full_o              = full;

  always_comb begin
    mem_d      = mem_q;
    ctrl_d     = ctrl_q;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    usage_d    = usage_q;
    ctrl_cnt_d = ctrl_cnt_q;
    if (push) begin
      mem_d[wptr_q]  = bus.decoded_instr_i;
      ctrl_d[wptr_q] = bus.is_ctrl_flow_i;
      wptr_d         = wptr_q + 1'b1;
    end
    if (pop) rptr_d = rptr_q + 1'b1;
    case ({push, pop})
      2'b10:   usage_d = usage_q + 1'b1;
      2'b01:   usage_d = usage_q - 1'b1;
      default: usage_d = usage_q;
    endcase
    case ({push && bus.is_ctrl_flow_i, pop && ctrl_q[rptr_q]})
      2'b10:   ctrl_cnt_d = ctrl_cnt_q + 1'b1;
      2'b01:   ctrl_cnt_d = ctrl_cnt_q - 1'b1;
      default: ctrl_cnt_d = ctrl_cnt_q;
    endcase
    if (bus.flush_i) begin
      wptr_d     = '0;
      rptr_d     = '0;
      usage_d    = '0;
      ctrl_cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      ctrl_q     <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      usage_q    <= '0;
      ctrl_cnt_q <= '0;
    end else begin
      mem_q      <= mem_d;
      ctrl_q     <= ctrl_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      usage_q    <= usage_d;
      ctrl_cnt_q <= ctrl_cnt_d;
    end
  end
endmodule

// File: tb/tb_issue_fifo.sv
// Directed bench for issue_fifo (DEPTH=4, MAX_CTRL=2); follows ISSUE_FIFO_BYPASS_EN when defined.
module tb_issue_fifo;
  import issue_fifo_pkg::*;

  localparam int DEPTH = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  issue_fifo_if #(.DEPTH(DEPTH)) bus();
  issue_fifo #(.DEPTH(DEPTH), .MAX_CTRL(2)) dut (.clk_i(clk), .rst_ni(rst_n), .bus(bus));

  always #5 clk = ~clk;

  function automatic scoreboard_entry_t mk(input logic [31:0] pc);
    scoreboard_entry_t e;
    e.pc = pc;
    e.op = pc[7:0] ^ 8'h5a;
    e.rd = pc[4:0];
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.flush_i               = 1'b0;
    bus.decoded_instr_valid_i = 1'b0;
    bus.is_ctrl_flow_i        = 1'b0;
    bus.issue_ack_i           = 1'b0;
    bus.decoded_instr_i       = '0;
    #1;
  endtask

  task automatic offer(input logic [31:0] pc, input logic ctrl, input logic ack);
    bus.flush_i               = 1'b0;
    bus.decoded_instr_valid_i = 1'b1;
    bus.decoded_instr_i       = mk(pc);
    bus.is_ctrl_flow_i        = ctrl;
    bus.issue_ack_i           = ack;
    #1;
  endtask

  task automatic test_reset();
    offer(32'h1, 1'b1, 1'b1);
    checks++; if (bus.decoded_instr_ack_o !== 1'b0) begin errors++; $display("FAIL reset_ack: got %0b want 0", bus.decoded_instr_ack_o); end
    checks++; if (bus.issue_instr_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b want 0", bus.issue_instr_valid_o); end
    checks++; if (bus.usage_o !== 3'd0) begin errors++; $display("FAIL reset_usage: got %0d want 0", bus.usage_o); end
    checks++; if (bus.full_o !== 1'b0) begin errors++; $display("FAIL reset_full: got %0b want 0", bus.full_o); end
    idle();
    checks++; if (bus.is_ctrl_flow_o !== 1'b0) begin errors++; $display("FAIL reset_ctrl: got %0b want 0", bus.is_ctrl_flow_o); end
    checks++; if (bus.issue_instr_o !== '0) begin errors++; $display("FAIL reset_storage: got %0h want 0", bus.issue_instr_o); end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_latency();
    offer(32'h40, 1'b0, 1'b1);
`ifdef ISSUE_FIFO_BYPASS_EN
    checks++; if (bus.issue_instr_valid_o !== 1'b1) begin errors++; $display("FAIL bypass_valid: got %0b want 1", bus.issue_instr_valid_o); end
    checks++; if (bus.issue_instr_o !== mk(32'h40)) begin errors++; $display("FAIL bypass_data: got %0h want %0h", bus.issue_instr_o, mk(32'h40)); end
    tick(); idle();
    checks++; if (bus.usage_o !== 3'd0) begin errors++; $display("FAIL bypass_usage: got %0d want 0", bus.usage_o); end
    checks++; if (bus.issue_instr_valid_o !== 1'b0) begin errors++; $display("FAIL bypass_after: got %0b want 0", bus.issue_instr_valid_o); end
`else
    checks++; if (bus.decoded_instr_ack_o !== 1'b1) begin errors++; $display("FAIL lat_ack: got %0b want 1", bus.decoded_instr_ack_o); end
    checks++; if (bus.issue_instr_valid_o !== 1'b0) begin errors++; $display("FAIL lat_same_cycle: got %0b want 0", bus.issue_instr_valid_o); end
    tick(); idle();
    checks++; if (bus.issue_instr_valid_o !== 1'b1) begin errors++; $display("FAIL lat_next_valid: got %0b want 1", bus.issue_instr_valid_o); end
    checks++; if (bus.issue_instr_o !== mk(32'h40)) begin errors++; $display("FAIL lat_data: got %0h want %0h", bus.issue_instr_o, mk(32'h40)); end
    checks++; if (bus.usage_o !== 3'd1) begin errors++; $display("FAIL lat_usage: got %0d want 1", bus.usage_o); end
    bus.issue_ack_i = 1'b1;
    tick(); idle();
    checks++; if (bus.usage_o !== 3'd0) begin errors++; $display("FAIL lat_drain: got %0d want 0", bus.usage_o); end
`endif
  endtask

  task automatic test_fill();
    for (int i = 0; i < 5; i++) begin
      offer(32'h10 + i, 1'b0, 1'b0);
      checks++; if (bus.decoded_instr_ack_o !== (i < 4)) begin errors++; $display("FAIL fill_ack%0d: got %0b want %0b", i, bus.decoded_instr_ack_o, (i < 4)); end
      tick();
    end
    idle();
    checks++; if (bus.full_o !== 1'b1) begin errors++; $display("FAIL fill_full: got %0b want 1", bus.full_o); end
    checks++; if (bus.usage_o !== 3'd4) begin errors++; $display("FAIL fill_usage: got %0d want 4", bus.usage_o); end
    for (int i = 0; i < 4; i++) begin
      bus.issue_ack_i = 1'b1;
      #1;
      checks++; if (bus.issue_instr_valid_o !== 1'b1) begin errors++; $display("FAIL fill_pop_valid%0d: got %0b want 1", i, bus.issue_instr_valid_o); end
      checks++; if (bus.issue_instr_o !== mk(32'h10 + i)) begin errors++; $display("FAIL fill_order%0d: got %0h want %0h", i, bus.issue_instr_o, mk(32'h10 + i)); end
      tick();
    end
    idle();
    checks++; if (bus.usage_o !== 3'd0) begin errors++; $display("FAIL fill_empty: got %0d want 0", bus.usage_o); end
    checks++; if (bus.full_o !== 1'b0) begin errors++; $display("FAIL fill_notfull: got %0b want 0", bus.full_o); end
  endtask

  task automatic test_ctrl_limit();
    for (int i = 0; i < 3; i++) begin
      offer(32'h20 + i, 1'b1, 1'b0);
      checks++; if (bus.decoded_instr_ack_o !== (i < 2)) begin errors++; $display("FAIL ctrl_ack%0d: got %0b want %0b", i, bus.decoded_instr_ack_o, (i < 2)); end
      tick();
    end
    offer(32'h22, 1'b1, 1'b1);
    checks++; if (bus.decoded_instr_ack_o !== 1'b0) begin errors++; $display("FAIL ctrl_pop_cycle_ack: got %0b want 0", bus.decoded_instr_ack_o); end
    checks++; if (bus.is_ctrl_flow_o !== 1'b1) begin errors++; $display("FAIL ctrl_head_flag: got %0b want 1", bus.is_ctrl_flow_o); end
    checks++; if (bus.issue_instr_o !== mk(32'h20)) begin errors++; $display("FAIL ctrl_head: got %0h want %0h", bus.issue_instr_o, mk(32'h20)); end
    tick();
    offer(32'h22, 1'b1, 1'b0);
    checks++; if (bus.decoded_instr_ack_o !== 1'b1) begin errors++; $display("FAIL ctrl_ack_after_pop: got %0b want 1", bus.decoded_instr_ack_o); end
    tick(); idle();
    checks++; if (bus.usage_o !== 3'd2) begin errors++; $display("FAIL ctrl_usage: got %0d want 2", bus.usage_o); end
    for (int i = 1; i < 3; i++) begin
      bus.issue_ack_i = 1'b1;
      #1;
      checks++; if (bus.issue_instr_o !== mk(32'h20 + i)) begin errors++; $display("FAIL ctrl_order%0d: got %0h want %0h", i, bus.issue_instr_o, mk(32'h20 + i)); end
      tick();
    end
    idle();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 2; i++) begin offer(32'h30 + i, 1'b0, 1'b0); tick(); end
    for (int i = 0; i < 10; i++) begin
      offer(32'h32 + i, 1'b0, 1'b1);
      checks++; if (bus.issue_instr_o !== mk(32'h30 + i)) begin errors++; $display("FAIL b2b_head%0d: got %0h want %0h", i, bus.issue_instr_o, mk(32'h30 + i)); end
      tick();
      checks++; if (bus.usage_o !== 3'd2) begin errors++; $display("FAIL b2b_usage%0d: got %0d want 2", i, bus.usage_o); end
    end
    for (int i = 0; i < 2; i++) begin offer(32'h3c + i, 1'b0, 1'b0); tick(); end
    offer(32'h3e, 1'b0, 1'b1);
    checks++; if (bus.decoded_instr_ack_o !== 1'b0) begin errors++; $display("FAIL b2b_full_ack: got %0b want 0", bus.decoded_instr_ack_o); end
    checks++; if (bus.full_o !== 1'b1) begin errors++; $display("FAIL b2b_full: got %0b want 1", bus.full_o); end
    tick(); idle();
    checks++; if (bus.usage_o !== 3'd3) begin errors++; $display("FAIL b2b_full_usage: got %0d want 3", bus.usage_o); end
    checks++; if (bus.issue_instr_o !== mk(32'h3b)) begin errors++; $display("FAIL b2b_full_head: got %0h want %0h", bus.issue_instr_o, mk(32'h3b)); end
    bus.issue_ack_i = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    idle();
  endtask

  task automatic test_flush();
    offer(32'h50, 1'b1, 1'b0); tick();
    offer(32'h51, 1'b1, 1'b0); tick();
    offer(32'h52, 1'b0, 1'b0); tick();
    idle();
    checks++; if (bus.usage_o !== 3'd3) begin errors++; $display("FAIL flush_pre_usage: got %0d want 3", bus.usage_o); end
    offer(32'h53, 1'b0, 1'b1);
    bus.flush_i = 1'b1;
    #1;
    checks++; if (bus.decoded_instr_ack_o !== 1'b0) begin errors++; $display("FAIL flush_ack: got %0b want 0", bus.decoded_instr_ack_o); end
    checks++; if (bus.issue_instr_valid_o !== 1'b0) begin errors++; $display("FAIL flush_valid: got %0b want 0", bus.issue_instr_valid_o); end
    tick(); idle();
    checks++; if (bus.usage_o !== 3'd0) begin errors++; $display("FAIL flush_usage: got %0d want 0", bus.usage_o); end
    checks++; if (bus.issue_instr_valid_o !== 1'b0) begin errors++; $display("FAIL flush_post_valid: got %0b want 0", bus.issue_instr_valid_o); end
    for (int i = 0; i < 2; i++) begin
      offer(32'h54 + i, 1'b1, 1'b0);
      checks++; if (bus.decoded_instr_ack_o !== 1'b1) begin errors++; $display("FAIL flush_ctrl_cleared%0d: got %0b want 1", i, bus.decoded_instr_ack_o); end
      tick();
    end
    idle();
    checks++; if (bus.usage_o !== 3'd2) begin errors++; $display("FAIL flush_refill: got %0d want 2", bus.usage_o); end
    checks++; if (bus.issue_instr_o !== mk(32'h54)) begin errors++; $display("FAIL flush_head: got %0h want %0h", bus.issue_instr_o, mk(32'h54)); end
    bus.issue_ack_i = 1'b1;
    tick(); tick();
    idle();
  endtask

  task automatic test_wrap();
    int q[$];
    int pushed = 0;
    int popped = 0;
    int cyc = 0;
    logic vi, ai, exp_ack, exp_valid;
    scoreboard_entry_t exp_data;
    while (popped < 20 && cyc < 400) begin
      vi = (pushed < 20) && ($urandom_range(0, 3) != 0);
      ai = ($urandom_range(0, 2) != 0);
      bus.flush_i               = 1'b0;
      bus.decoded_instr_valid_i = vi;
      bus.decoded_instr_i       = mk(32'h100 + pushed);
      bus.is_ctrl_flow_i        = 1'b0;
      bus.issue_ack_i           = ai;
      #1;
      exp_ack   = vi && (q.size() < DEPTH);
      exp_valid = (q.size() != 0);
      exp_data  = (q.size() != 0) ? mk(32'h100 + q[0]) : '0;
`ifdef ISSUE_FIFO_BYPASS_EN
      if (q.size() == 0 && exp_ack) begin exp_valid = 1'b1; exp_data = mk(32'h100 + pushed); end
`endif
      checks++; if (bus.decoded_instr_ack_o !== exp_ack) begin errors++; $display("FAIL wrap_ack c%0d: got %0b want %0b", cyc, bus.decoded_instr_ack_o, exp_ack); end
      checks++; if (bus.issue_instr_valid_o !== exp_valid) begin errors++; $display("FAIL wrap_valid c%0d: got %0b want %0b", cyc, bus.issue_instr_valid_o, exp_valid); end
      if (exp_valid) begin
        checks++; if (bus.issue_instr_o !== exp_data) begin errors++; $display("FAIL wrap_data c%0d: got %0h want %0h", cyc, bus.issue_instr_o, exp_data); end
      end
      if (exp_valid && ai && q.size() == 0) begin
        pushed++; popped++;
      end else begin
        if (exp_valid && ai) begin void'(q.pop_front()); popped++; end
        if (exp_ack) begin q.push_back(pushed); pushed++; end
      end
      tick();
      cyc++;
    end
    idle();
    checks++; if (popped !== 20) begin errors++; $display("FAIL wrap_count: got %0d want 20", popped); end
    checks++; if (bus.usage_o !== 3'd0) begin errors++; $display("FAIL wrap_empty: got %0d want 0", bus.usage_o); end
  endtask

  task automatic test_reset_mid();
    offer(32'h60, 1'b1, 1'b0); tick();
    offer(32'h61, 1'b0, 1'b0); tick();
    offer(32'h62, 1'b0, 1'b1);
    #1;
    rst_n = 1'b0;
    #1;
    checks++; if (bus.usage_o !== 3'd0) begin errors++; $display("FAIL rstmid_usage: got %0d want 0", bus.usage_o); end
    checks++; if (bus.issue_instr_valid_o !== 1'b0) begin errors++; $display("FAIL rstmid_valid: got %0b want 0", bus.issue_instr_valid_o); end
    checks++; if (bus.decoded_instr_ack_o !== 1'b0) begin errors++; $display("FAIL rstmid_ack: got %0b want 0", bus.decoded_instr_ack_o); end
    tick();
    idle();
    rst_n = 1'b1;
    tick();
    checks++; if (bus.usage_o !== 3'd0) begin errors++; $display("FAIL rstmid_post_usage: got %0d want 0", bus.usage_o); end
    checks++; if (bus.issue_instr_o !== '0) begin errors++; $display("FAIL rstmid_storage: got %0h want 0", bus.issue_instr_o); end
    checks++; if (bus.is_ctrl_flow_o !== 1'b0) begin errors++; $display("FAIL rstmid_ctrl: got %0b want 0", bus.is_ctrl_flow_o); end
  endtask

  initial begin
    idle();
    test_reset();
    test_latency();
    test_fill();
    test_ctrl_limit();
    test_back_to_back();
    test_flush();
    test_wrap();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/issue_fifo.md
ISSUE_FIFO -- requirements
Module: issue_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 4: number of decoded-instruction entries; power of two, at least 2.
REQ-002 SHALL have parameter MAX_CTRL, default 2: maximum control-flow entries held at once; range 1..DEPTH.
REQ-003 SHALL have port clk_i, input, 1 bit: single clock; all state on rising edge.
REQ-004 SHALL have port rst_ni, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port flush_i, input, 1 bit: discard all buffered entries.
REQ-006 SHALL have port decoded_instr_i, input, scoreboard_entry_t: entry from decode.
REQ-007 SHALL have port decoded_instr_valid_i, input, 1 bit: decode offers an entry.
REQ-008 SHALL have port is_ctrl_flow_i, input, 1 bit: offered entry is branch/jump.
REQ-009 SHALL have port decoded_instr_ack_o, output, 1 bit: entry accepted this cycle.
REQ-010 SHALL have port issue_instr_o, output, scoreboard_entry_t: head entry to issue_stage.
REQ-011 SHALL have port issue_instr_valid_o, output, 1 bit: head entry valid.
REQ-012 SHALL have port is_ctrl_flow_o, output, 1 bit: head entry is branch/jump.
REQ-013 SHALL have port issue_ack_i, input, 1 bit: issue_stage consumed head.
REQ-014 SHALL have port usage_o, output, $clog2(DEPTH)+1 bits: current occupancy.
REQ-015 SHALL have port full_o, output, 1 bit: usage_o == DEPTH.

Function
REQ-016 SHALL push when decoded_instr_valid_i && decoded_instr_ack_o; SHALL pop when issue_instr_valid_o && issue_ack_i.
REQ-017 SHALL drive decoded_instr_ack_o = valid_i && !full_o && !flush_i && !(is_ctrl_flow_i && ctrl_cnt == MAX_CTRL); a same-cycle pop SHALL NOT free space for a push.
REQ-018 SHALL drive issue_instr_valid_o = (usage_o != 0) && !flush_i; issue_instr_o/is_ctrl_flow_o SHALL show the oldest entry (FIFO order).
REQ-019 SHALL hold issue_instr_o stable while issue_instr_valid_o high and issue_ack_i low.
REQ-020 SHALL use read/write pointers of $clog2(DEPTH) bits wrapping from DEPTH-1 to 0.
REQ-021 SHALL update usage_o: +1 push only, -1 pop only, unchanged on both or neither.
REQ-022 SHALL keep ctrl_cnt: +1 on pushing a ctrl entry, -1 on popping a ctrl entry, unchanged when both occur.
REQ-023 SHALL, with flush_i high, clear pointers, usage_o and ctrl_cnt next edge; push/pop suppressed that cycle.
REQ-024 SHALL have latency of one cycle from push to issue_instr_valid_o in default build.
REQ-025 SHALL ignore issue_ack_i when issue_instr_valid_o is low.

Reset
REQ-026 SHALL, on rst_ni low (asynchronous), clear pointers, usage_o=0, ctrl_cnt=0; issue_instr_valid_o=0, decoded_instr_ack_o=0, full_o=0, is_ctrl_flow_o=0.
REQ-027 SHALL drop in-flight entries on reset asserted mid-operation; no push/pop completes in that cycle.
REQ-028 SHALL reset storage array contents to zero.

Configuration
REQ-029 SHALL provide macro ISSUE_FIFO_BYPASS_EN.
REQ-030 SHALL, with ISSUE_FIFO_BYPASS_EN defined and FIFO empty, present decoded_instr_i combinationally on issue_instr_o with issue_instr_valid_o = decoded_instr_valid_i && decoded_instr_ack_o (zero latency); if issue_ack_i is high that cycle, entry SHALL NOT be stored and usage_o/ctrl_cnt SHALL NOT change.
REQ-031 SHALL, without ISSUE_FIFO_BYPASS_EN, have no input-to-output combinational path; latency per REQ-024.

Verification
REQ-032 SHALL test fill: DEPTH=4, push 5 entries with issue_ack_i=0 -> 4 acked, full_o=1, usage_o=4, 5th ack=0; pop order = push order.
REQ-033 SHALL test ctrl limit: MAX_CTRL=2, push 3 ctrl entries, no pop -> third ack=0; one pop of ctrl head -> third acked next cycle.
REQ-034 SHALL test simultaneous push/pop at usage_o=2 -> usage_o stays 2 for 10 cycles; at full -> push not acked, usage_o drops to 3.
REQ-035 SHALL test flush with usage_o=3 -> next cycle usage_o=0, issue_instr_valid_o=0, ctrl_cnt=0; flush-cycle push rejected.
REQ-036 SHALL test wrap-around: 20 push/pop pairs through DEPTH=4 with random stalls -> no loss, duplication or reorder.
REQ-037 SHALL test bypass (macro on): empty FIFO, valid_i=1, issue_ack_i=1 -> same-cycle output equal to input, usage_o stays 0; macro off -> valid one cycle later.
